// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with pipeline stall/flush handshake.
// Special cases (divide by zero, signed overflow) finish in a single cycle.
module div_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      alu_sel,
  input  logic            is_unsigned,
  input  logic            flush,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW      = $clog2(XLEN + 1);
  localparam logic [3:0]  SEL_DIV = 4'd9;
  localparam logic [3:0]  SEL_REM = 4'd10;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] quo, rem, dvs;
  logic [CW-1:0]   cnt;
  logic [3:0]      sel_q;
  logic            neg_q, neg_r;

  logic            accept, special, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] a_mag, b_mag, q_fix, r_fix, min_neg;
  logic [XLEN:0]   shifted, diff;

  assign min_neg  = {1'b1, {(XLEN-1){1'b0}}};
  assign accept   = rst_n && (state == IDLE) && start && !flush &&
                    ((alu_sel == SEL_DIV) || (alu_sel == SEL_REM));
  assign div_zero = (op_b == '0);
  assign ovf      = !is_unsigned && (op_a == min_neg) && (op_b == '1);
  assign special  = div_zero || ovf;
  assign a_neg    = !is_unsigned && op_a[XLEN-1];
  assign b_neg    = !is_unsigned && op_b[XLEN-1];
  assign a_mag    = a_neg ? (~op_a + XLEN'(1)) : op_a;
  assign b_mag    = b_neg ? (~op_b + XLEN'(1)) : op_b;

  // Restoring step: shift next dividend bit into the partial remainder and trial-subtract.
  assign shifted  = {rem, quo[XLEN-1]};
  assign diff     = shifted - {1'b0, dvs};
  assign q_fix    = neg_q ? (~quo + XLEN'(1)) : quo;
  assign r_fix    = neg_r ? (~rem + XLEN'(1)) : rem;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: if (flush) state_nxt = IDLE;
            else if (cnt == CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = flush ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; stall is combinational so the accept cycle is already frozen.
  always_comb begin
    stall = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    stall = accept || (state == CALC) || (state == FIX);
    busy  = (state != IDLE);
    done  = (state == DONE) && !flush;
  end

  // Datapath: operand latch, iteration, sign fix-up and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      sel_q  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (accept) begin
      sel_q <= alu_sel;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      quo   <= a_mag;
      dvs   <= b_mag;
      rem   <= '0;
      if (div_zero)  result <= (alu_sel == SEL_REM) ? op_a : '1;
      else if (ovf)  result <= (alu_sel == SEL_REM) ? '0 : min_neg;
      else           cnt    <= CW'(XLEN);
    end else if ((state == CALC) && !flush) begin
      cnt <= cnt - CW'(1);
      if (!diff[XLEN]) begin
        rem <= diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= shifted[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end
    end else if ((state == FIX) && !flush) begin
      result <= (sel_q == SEL_REM) ? r_fix : q_fix;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer (XLEN=32).
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, is_unsigned, flush;
  logic [3:0]  alu_sel;
  logic [31:0] op_a, op_b;
  logic        stall, busy, done;
  logic [31:0] result;

  int passes = 0;
  int total  = 0;

  div_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_sel(alu_sel),
    .is_unsigned(is_unsigned), .flush(flush), .op_a(op_a), .op_b(op_b),
    .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and watch up to 40 cycles after the accept edge.
  task automatic run_op(input logic [3:0] sel, input logic uns, input logic [31:0] a,
                        input logic [31:0] b, output int done_edge, output int done_cnt,
                        output bit stall_ok, output logic [31:0] res);
    done_edge = -1;
    done_cnt  = 0;
    stall_ok  = 1'b1;
    res       = 'x;
    alu_sel = sel; is_unsigned = uns; op_a = a; op_b = b; start = 1'b1;
    #1;
    if (stall !== 1'b1) stall_ok = 1'b0;
    edge1();
    start = 1'b0;
    for (int e = 0; e < 40; e++) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = e;
          res = result;
          if (stall !== 1'b0) stall_ok = 1'b0;
        end
      end else if (done_edge < 0 && e > 0 && stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
      edge1();
    end
  endtask

  int          de, dc;
  bit          sok;
  logic [31:0] r;

  initial begin
    rst_n = 1'b0; start = 1'b0; alu_sel = 4'd0; is_unsigned = 1'b0;
    flush = 1'b0; op_a = '0; op_b = '0;
    #12;
    check("reset_busy",   {31'd0, busy},  32'd0);
    check("reset_done",   {31'd0, done},  32'd0);
    check("reset_result", result,         32'd0);
    check("reset_stall",  {31'd0, stall}, 32'd0);
    edge1();
    rst_n = 1'b1;

    // Unsigned DIV 100/7
    run_op(4'd9, 1'b1, 32'd100, 32'd7, de, dc, sok, r);
    check("divu_100_7_result", r, 32'd14);
    check("divu_100_7_edge", de, 33);
    check("divu_100_7_pulses", dc, 1);
    check("divu_100_7_stall", {31'd0, sok}, 32'd1);

    // Signed REM/DIV -7 by 2
    run_op(4'd10, 1'b0, 32'hFFFF_FFF9, 32'd2, de, dc, sok, r);
    check("rem_m7_2_result", r, 32'hFFFF_FFFF);
    check("rem_m7_2_edge", de, 33);
    run_op(4'd9, 1'b0, 32'hFFFF_FFF9, 32'd2, de, dc, sok, r);
    check("div_m7_2_result", r, 32'hFFFF_FFFD);

    // Same bits treated as unsigned
    run_op(4'd10, 1'b1, 32'hFFFF_FFF9, 32'd2, de, dc, sok, r);
    check("remu_big_2_result", r, 32'd1);
    run_op(4'd9, 1'b1, 32'hFFFF_FFFF, 32'h10, de, dc, sok, r);
    check("divu_big_16_result", r, 32'h0FFF_FFFF);

    // Divide by zero
    run_op(4'd9, 1'b0, 32'd5, 32'd0, de, dc, sok, r);
    check("div0_div_result", r, 32'hFFFF_FFFF);
    check("div0_div_edge", de, 0);
    check("div0_div_pulses", dc, 1);
    run_op(4'd10, 1'b0, 32'd5, 32'd0, de, dc, sok, r);
    check("div0_rem_result", r, 32'd5);
    check("div0_rem_edge", de, 0);

    // Signed overflow (REM first so the DIV value is left for the flush test)
    run_op(4'd10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, de, dc, sok, r);
    check("ovf_rem_result", r, 32'd0);
    check("ovf_rem_edge", de, 0);
    run_op(4'd9, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, de, dc, sok, r);
    check("ovf_div_result", r, 32'h8000_0000);
    check("ovf_div_edge", de, 0);

    // Flush at CALC cycle 10
    alu_sel = 4'd9; is_unsigned = 1'b1; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    edge1();
    start = 1'b0;
    dc = 0;
    for (int e = 1; e <= 10; e++) begin
      edge1();
      if (done === 1'b1) dc++;
    end
    check("flush_pre_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    edge1();
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    for (int e = 0; e < 30; e++) begin
      if (done === 1'b1) dc++;
      edge1();
    end
    check("flush_no_done", dc, 0);
    check("flush_result_held", result, 32'h8000_0000);
    run_op(4'd9, 1'b0, 32'd9, 32'd3, de, dc, sok, r);
    check("after_flush_div_result", r, 32'd3);
    check("after_flush_div_edge", de, 33);

    // Flush together with start in IDLE
    alu_sel = 4'd9; op_a = 32'd8; op_b = 32'd2; start = 1'b1; flush = 1'b1;
    #1;
    check("flush_start_stall", {31'd0, stall}, 32'd0);
    edge1();
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);

    // Reset mid-CALC
    alu_sel = 4'd9; is_unsigned = 1'b1; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    edge1();
    start = 1'b0;
    for (int e = 0; e < 5; e++) edge1();
    rst_n = 1'b0;
    #1;
    check("midrst_busy",   {31'd0, busy},  32'd0);
    check("midrst_done",   {31'd0, done},  32'd0);
    check("midrst_result", result,         32'd0);
    check("midrst_stall",  {31'd0, stall}, 32'd0);
    start = 1'b1;
    #1;
    check("midrst_start_stall", {31'd0, stall}, 32'd0);
    start = 1'b0;
    edge1();
    rst_n = 1'b1;
    edge1();

    // Non-divide selector is ignored
    alu_sel = 4'd2; op_a = 32'd8; op_b = 32'd2; start = 1'b1;
    #1;
    check("add_sel_stall", {31'd0, stall}, 32'd0);
    edge1();
    start = 1'b0;
    check("add_sel_busy", {31'd0, busy}, 32'd0);
    check("add_sel_result", result, 32'd0);

    // First accept after reset
    run_op(4'd10, 1'b1, 32'd100, 32'd7, de, dc, sok, r);
    check("post_rst_rem_result", r, 32'd2);
    check("post_rst_rem_edge", de, 33);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; iteration count equals XLEN.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request from execute stage, sampled at rising edge.
REQ-005 alu_sel  input  4  ALU selector; 9 = DIV, 10 = REM; other codes never start an operation.
REQ-006 is_unsigned  input  1  1 = unsigned (DIVU/REMU), 0 = signed.
REQ-007 flush  input  1  pipeline flush (taken branch/jump); aborts the operation.
REQ-008 op_a  input  XLEN  dividend.
REQ-009 op_b  input  XLEN  divisor.
REQ-010 stall  output  1  freezes the pipeline front end while an operation is in flight.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse; result valid.
REQ-013 result  output  XLEN  quotient (DIV) or remainder (REM).

Function
REQ-014 States: IDLE, CALC, FIX, DONE.
REQ-015 Accept condition: state IDLE, start=1, alu_sel in {9,10}, flush=0.
- On accept: latch op_a, op_b, alu_sel and is_unsigned.
- start at any other time: ignored.
REQ-016 Divisor zero on accept -> next state DONE.
- DIV result: all ones.
- REM result: op_a.
REQ-017 Signed overflow on accept (is_unsigned=0, op_a=0x80000000, op_b=all ones) -> next state DONE.
- DIV result: 0x80000000.
- REM result: 0.
REQ-018 All other accepts -> next state CALC.
- Signed mode: operands converted to magnitudes.
- Counter loaded with XLEN.
REQ-019 CALC: one restoring-division step per cycle, shifting one quotient bit in.
- Counter decrements each cycle.
- After XLEN cycles -> FIX.
REQ-020 FIX (one cycle), signed mode only:
- Quotient negated when operand signs differ.
- Remainder takes the sign of the dividend.
- result loaded per the latched alu_sel.
- Next state DONE.
REQ-021 DONE (one cycle): done=1, then next state IDLE; a new start is accepted no earlier than the IDLE cycle.
REQ-022 Latency, counting the accept edge as edge 0:
- normal operation: done high in the cycle after edge XLEN+1 (edge 33 for XLEN=32);
- special case: done high in the cycle after edge 0.
REQ-023 stall is combinational: (accept condition true) OR state CALC OR state FIX; stall=0 in DONE so the pipeline captures result.
REQ-024 result holds its value from DONE until the next DONE; it is not modified by flush or by ignored starts.
REQ-025 flush=1 in CALC, FIX or DONE: next state IDLE, no done pulse, result unchanged.
REQ-026 flush=1 together with start in IDLE: no accept; stall stays 0.
REQ-027 Remainder and quotient arithmetic is modulo 2^XLEN with no other exceptions or traps.

Reset
REQ-028 rst_n low, asynchronously and at any state including mid-CALC, forces:
- state IDLE, counter 0;
- done=0, busy=0, result=0, all internal registers 0;
- stall=0 while rst_n is low.
REQ-029 The first accept is permitted on the first rising edge after rst_n deasserts.

Verification
REQ-030 The bench shall cover these directed scenarios:
- Unsigned DIV: op_a=100, op_b=7 -> stall high from accept through FIX; result 14; single done pulse 34 cycles after accept.
- Signed REM and DIV: op_a=0xFFFFFFF9 (-7), op_b=2 -> REM result 0xFFFFFFFF (-1); repeated as DIV -> result 0xFFFFFFFD (-3).
- Divide by zero: DIV with op_a=5, op_b=0 -> result 0xFFFFFFFF, done in cycle after accept; REM with the same operands -> result 5.
- Signed overflow: op_a=0x80000000, op_b=0xFFFFFFFF -> DIV result 0x80000000; REM result 0; both with one-cycle latency.
- Flush mid-operation: flush at CALC cycle 10 -> IDLE next cycle, no done, result retains its previous value; a new DIV 9/3 then yields 3.
- Reset mid-operation, plus start with alu_sel=2 (ADD):
  - rst_n pulsed low mid-CALC -> outputs zero immediately;
  - start with alu_sel=2 -> no busy, no stall.
